// File: rtl/piano_pkg.sv
// Shared encodings, window limits and sequencer state enum for the piano blocks.
package piano_pkg;

    localparam logic [2:0] MODE_STUDY     = 3'b001;
    localparam logic [2:0] MODE_CHALLENGE = 3'b101;

    localparam logic [2:0] DIFF_EASY   = 3'b100;
    localparam logic [2:0] DIFF_NORMAL = 3'b010;
    localparam logic [2:0] DIFF_HARD   = 3'b001;

    localparam int unsigned WIN_W = 7;
    localparam logic [WIN_W-1:0] INTERVAL_EASY   = 7'd60;
    localparam logic [WIN_W-1:0] INTERVAL_NORMAL = 7'd45;
    localparam logic [WIN_W-1:0] INTERVAL_HARD   = 7'd30;

    localparam logic [7:0] END_MARKER = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_CUR,
        ST_FETCH_NEXT,
        ST_PLAY,
        ST_ADVANCE,
        ST_DONE
    } seq_state_e;

    // Tick budget for one note; unknown codes fall back to the easy window.
    function automatic logic [WIN_W-1:0] window_limit(input logic [2:0] diff);
        case (diff)
            DIFF_NORMAL: window_limit = INTERVAL_NORMAL;
            DIFF_HARD:   window_limit = INTERVAL_HARD;
            default:     window_limit = INTERVAL_EASY;
        endcase
    endfunction

endpackage

// File: rtl/seq_window_timer.sv
// Per-note beat window: counts ticks while enabled, clears when disabled.
// expired is asserted in the cycle whose tick reaches the limit, or at once
// when the limit drops to or below the running count.
module seq_window_timer
    import piano_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick,
    input  logic [WIN_W-1:0] limit,
    output logic             expired
);

    logic [WIN_W-1:0] win_cnt;

    // Saturating tick counter, held at zero outside the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= '0;
        end else if (!en) begin
            win_cnt <= '0;
        end else if (tick && (win_cnt != '1)) begin
            win_cnt <= win_cnt + WIN_W'(1);
        end
    end

    assign expired = en &&
        (({1'b0, win_cnt} + {{WIN_W{1'b0}}, tick}) >= {1'b0, limit});

endmodule

// File: rtl/note_sequencer.sv
// Song-stepping controller: walks the song ROM, shows current/next note,
// scores key presses and flags the end of the song.
// Optional macro NOTE_SEQ_SCORE_EN builds the hit/miss counters; when it is
// undefined both counter outputs are tied to zero.
module note_sequencer
    import piano_pkg::*;
#(
    parameter int unsigned AW    = 9,
    parameter int unsigned CNT_W = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       state,
    input  logic [2:0]       difficulty,
    input  logic             tick,
    input  logic [7:0]       key_in,
    output logic [AW-1:0]    rom_addr,
    input  logic [7:0]       rom_data,
    output logic [7:0]       note_led,
    output logic [7:0]       next_note_led,
    output logic             isEnd,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    seq_state_e    fsm_q, fsm_n;
    logic [AW-1:0] idx_q, idx_n;
    logic [AW-1:0] addr_n;
    logic [7:0]    note_n, next_n;
    logic          end_n;
    logic [7:0]    key_prev;
    logic [2:0]    mode_q;

    logic       active, challenge, restart;
    logic [7:0] rise;
    logic       press, hit, expired, timeout;

    assign active    = (state == MODE_STUDY) || (state == MODE_CHALLENGE);
    assign challenge = (state == MODE_CHALLENGE);
    assign restart   = active && (fsm_q != ST_IDLE) && (state != mode_q);

    assign rise    = key_in & ~key_prev;
    assign press   = (fsm_q == ST_PLAY) && (rise != 8'h00);
    assign hit     = press && (key_in == note_led) && ((rise & note_led) != 8'h00);
    assign timeout = (fsm_q == ST_PLAY) && challenge && expired;

    seq_window_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (fsm_q == ST_PLAY),
        .tick    (tick),
        .limit   (window_limit(difficulty)),
        .expired (expired)
    );

    // State, index, ROM address and LED registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q         <= ST_IDLE;
            idx_q         <= '0;
            rom_addr      <= '0;
            note_led      <= '0;
            next_note_led <= '0;
            isEnd         <= 1'b0;
            key_prev      <= '0;
            mode_q        <= '0;
        end else begin
            fsm_q         <= fsm_n;
            idx_q         <= idx_n;
            rom_addr      <= addr_n;
            note_led      <= note_n;
            next_note_led <= next_n;
            isEnd         <= end_n;
            key_prev      <= key_in;
            mode_q        <= state;
        end
    end

    // Next-state and next-output logic; mode exit and mode switch take priority.
    always_comb begin
        fsm_n  = fsm_q;
        idx_n  = idx_q;
        addr_n = rom_addr;
        note_n = note_led;
        next_n = next_note_led;
        end_n  = isEnd;

        if (!active || restart) begin
            fsm_n  = active ? ST_FETCH_CUR : ST_IDLE;
            idx_n  = '0;
            addr_n = '0;
            note_n = '0;
            next_n = '0;
            end_n  = 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    addr_n = '0;
                    fsm_n  = ST_FETCH_CUR;
                end
                ST_FETCH_CUR: begin
                    note_n = rom_data;
                    addr_n = idx_q + AW'(1);
                    if (rom_data == END_MARKER) begin
                        fsm_n = ST_DONE;
                        end_n = 1'b1;
                    end else begin
                        fsm_n = ST_FETCH_NEXT;
                    end
                end
                ST_FETCH_NEXT: begin
                    // The top ROM location is always the last note.
                    next_n = (idx_q == '1) ? END_MARKER : rom_data;
                    fsm_n  = ST_PLAY;
                end
                ST_PLAY: begin
                    if (hit || timeout) begin
                        fsm_n = ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    note_n = next_note_led;
                    idx_n  = idx_q + AW'(1);
                    if (next_note_led == END_MARKER) begin
                        fsm_n  = ST_DONE;
                        end_n  = 1'b1;
                        note_n = '0;
                        next_n = '0;
                    end else begin
                        addr_n = idx_q + AW'(2);
                        fsm_n  = ST_FETCH_NEXT;
                    end
                end
                ST_DONE: begin
                    note_n = '0;
                    next_n = '0;
                end
                default: begin
                    fsm_n = ST_IDLE;
                end
            endcase
        end
    end

`ifdef NOTE_SEQ_SCORE_EN
    logic [CNT_W-1:0] hit_q, miss_q;
    logic             cnt_clr, wrong;

    assign cnt_clr = !active || restart;
    assign wrong   = press && !hit && challenge;

    // Saturating score counters; a hit outranks a timeout or wrong press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (cnt_clr) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (hit) begin
            if (hit_q != '1) hit_q <= hit_q + CNT_W'(1);
        end else if (timeout || wrong) begin
            if (miss_q != '1) miss_q <= miss_q + CNT_W'(1);
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule
